alu_md: RTL
===========

ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values are powers of two, 8 to 64.
REQ-002 SHALL have parameter SHW, default $clog2(XLEN), shift-amount width taken from iv_B[SHW-1:0].
REQ-003 SHALL have port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_valid  input  1  operation request; accepted when i_valid & o_ready.
REQ-006 SHALL have port o_ready  output  1  high when the block can accept an operation (state IDLE).
REQ-007 SHALL have port iv_A  input  XLEN  operand A / dividend / multiplicand.
REQ-008 SHALL have port iv_B  input  XLEN  operand B / divisor / multiplier / shift amount.
REQ-009 SHALL have port iv_ALUop  input  5  operation code, sampled only on accept.
REQ-010 SHALL have port o_valid  output  1  one-cycle pulse marking a new ov_result.
REQ-011 SHALL have port ov_result  output  XLEN  registered result, held until the next o_valid.
REQ-012 SHALL have port o_zero_flag  output  1  high when ov_result is zero.

Function
REQ-013 SHALL implement single-cycle ops: 0_0000 add, 0_0010 sub, 0_0100 sll, 0_1000 slt, 0_1100 sltu, 1_0000 xor, 1_0100 srl, 1_0110 sra, 1_1000 or, 1_1100 and, 1_1010 bge (signed A>=B ->1), 1_1110 bgeu, 1_1101 pass B (LUI).
REQ-014 SHALL implement multi-cycle ops: 0_0001 mul (low XLEN), 0_0011 mulh (s x s high), 0_0101 mulhsu (A signed x B unsigned, high), 0_0111 mulhu (u x u high), 0_1001 div, 0_1011 divu, 0_1101 rem, 0_1111 remu.
REQ-015 SHALL produce result 0 with single-cycle latency for any other code.
REQ-016 SHALL compute add/sub/shift results modulo 2^XLEN; shifts use only iv_B[SHW-1:0]; comparison results are zero-extended 1 or 0.
REQ-017 SHALL use states IDLE, RUN, FIX: IDLE --accept multi-cycle op--> RUN; RUN --after exactly XLEN iterations--> FIX; FIX --1 cycle--> IDLE.
REQ-018 SHALL, on accept of a single-cycle op in cycle N, register the result and assert o_valid in cycle N+1; state stays IDLE.
REQ-019 SHALL, on accept of a multi-cycle op in cycle N, assert o_valid in cycle N+XLEN+1 exactly (1 load edge, XLEN iteration edges; result registered at FIX edge).
REQ-020 SHALL perform multiply as unsigned shift-add on operand magnitudes (one bit per RUN cycle) and divide as restoring division (one quotient bit per RUN cycle); FIX applies sign correction.
REQ-021 SHALL, for divide by zero, return quotient all ones (div, divu) and remainder = dividend (rem, remu).
REQ-022 SHALL, for div/rem with A = most-negative and B = -1, return quotient = A and remainder = 0.
REQ-023 SHALL give signed remainders the sign of the dividend; quotients truncate toward zero.
REQ-024 SHALL hold o_ready low in RUN and FIX; i_valid there is ignored and not queued.
REQ-025 SHALL allow a new accept in the same cycle o_valid is high (back-to-back ops).
REQ-026 SHALL keep ov_result and o_zero_flag stable between o_valid pulses; no output back-pressure exists.

Reset
REQ-027 SHALL, while i_rst is high at a clock edge, force state IDLE, o_valid 0, ov_result 0, o_zero_flag 1, o_ready 1 after that edge.
REQ-028 SHALL abort any in-flight multi-cycle op on reset; no o_valid for the aborted op ever appears.
REQ-029 SHALL give reset priority over a simultaneous i_valid; that request is dropped.

Verification (XLEN=32)
REQ-030 SHALL cover add A=5 B=7 accepted cycle N -> o_valid cycle N+1, ov_result 12, o_zero_flag 0.
REQ-031 SHALL cover sra A=0x80000000 B=0x24 -> 0xF8000000 (shift 4); sub 3-3 -> 0, o_zero_flag 1.
REQ-032 SHALL cover mul then mulh with A=0xFFFFFFFF B=2 -> 0xFFFFFFFE then 0xFFFFFFFF, each o_valid exactly 33 cycles after accept, o_ready low 32 cycles.
REQ-033 SHALL cover div/rem A=0x80000000 B=0xFFFFFFFF -> 0x80000000 / 0; divu/remu A=100 B=0 -> 0xFFFFFFFF / 100; div A=-7 B=2 -> -3, rem -> -1.
REQ-034 SHALL cover i_rst high 10 cycles into a divu -> next cycle o_ready 1, ov_result 0, no o_valid within 40 cycles; i_valid pulses during RUN are ignored.
REQ-035 SHALL cover random ops against a reference model over 10000 transactions, with back-to-back accepts.

Source files
------------

// File: rtl/alu_md.sv
// -----------------------------------------------------------------------------
// alu_md -- integer ALU with an iterative multiply/divide unit.
//
// Single-cycle operations (add/sub/logic/shift/compare/pass-B) return their
// result one cycle after accept. Multiply and divide operations run through a
// shared iterative datapath that processes one bit per cycle. For these the
// block is busy for XLEN cycles, and the result appears XLEN+1 cycles after
// accept.
//
// Ports
//   i_clk        sole clock, rising edge
//   i_rst        synchronous active-high reset
//   i_valid      operation request, accepted when i_valid & o_ready
//   o_ready      high while idle (able to accept)
//   iv_A         operand A / dividend / multiplicand
//   iv_B         operand B / divisor / multiplier / shift amount
//   iv_ALUop     5-bit operation code, sampled on accept
//   o_valid      one-cycle pulse marking a new ov_result
//   ov_result    registered result, held between o_valid pulses
//   o_zero_flag  high when ov_result is zero
// -----------------------------------------------------------------------------
module alu_md #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] iv_A,
  input  logic [XLEN-1:0] iv_B,
  input  logic [4:0]      iv_ALUop,
  output logic            o_valid,
  output logic [XLEN-1:0] ov_result,
  output logic            o_zero_flag
);

  // Single-cycle operation codes
  localparam logic [4:0] OP_ADD    = 5'b0_0000;
  localparam logic [4:0] OP_SUB    = 5'b0_0010;
  localparam logic [4:0] OP_SLL    = 5'b0_0100;
  localparam logic [4:0] OP_SLT    = 5'b0_1000;
  localparam logic [4:0] OP_SLTU   = 5'b0_1100;
  localparam logic [4:0] OP_XOR    = 5'b1_0000;
  localparam logic [4:0] OP_SRL    = 5'b1_0100;
  localparam logic [4:0] OP_SRA    = 5'b1_0110;
  localparam logic [4:0] OP_OR     = 5'b1_1000;
  localparam logic [4:0] OP_AND    = 5'b1_1100;
  localparam logic [4:0] OP_BGE    = 5'b1_1010;
  localparam logic [4:0] OP_BGEU   = 5'b1_1110;
  localparam logic [4:0] OP_LUI    = 5'b1_1101;
  // Multi-cycle operation codes
  localparam logic [4:0] OP_MUL    = 5'b0_0001;
  localparam logic [4:0] OP_MULH   = 5'b0_0011;
  localparam logic [4:0] OP_MULHSU = 5'b0_0101;
  localparam logic [4:0] OP_MULHU  = 5'b0_0111;
  localparam logic [4:0] OP_DIV    = 5'b0_1001;
  localparam logic [4:0] OP_DIVU   = 5'b0_1011;
  localparam logic [4:0] OP_REM    = 5'b0_1101;
  localparam logic [4:0] OP_REMU   = 5'b0_1111;

  localparam int CW = $clog2(XLEN);
  // The load edge only captures operands, RUN performs XLEN-1 iterations and
  // the FIX edge performs the last one together with sign correction.
  localparam logic [CW-1:0] LAST_RUN = CW'(XLEN - 2);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [CW-1:0]   r_cnt;
  logic [4:0]      r_op;
  logic [XLEN-1:0] r_hi;      // product high half / partial remainder
  logic [XLEN-1:0] r_lo;      // multiplier bits / dividend bits -> quotient
  logic [XLEN-1:0] r_opnd;    // multiplicand or divisor magnitude
  logic            r_neg_q;   // product or quotient must be negated
  logic            r_neg_r;   // remainder must be negated
  logic            r_div0;
  logic            r_valid;
  logic [XLEN-1:0] r_result;
  logic            r_zero;

  logic            w_ready;
  logic            w_accept;
  logic            w_is_md;
  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_alu;
  logic            w_a_sgn;
  logic            w_b_sgn;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic [XLEN:0]   w_msum;
  logic [XLEN:0]   w_shift;
  logic            w_ge;
  logic [XLEN-1:0] w_step_hi;
  logic [XLEN-1:0] w_step_lo;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0] w_quo;
  logic [XLEN-1:0] w_rem;
  logic [XLEN-1:0] w_fix;

  assign w_ready  = (r_state == IDLE);
  assign w_accept = i_valid & w_ready;
  // Multiply/divide codes are exactly those with bit 4 clear and bit 0 set.
  assign w_is_md  = ~iv_ALUop[4] & iv_ALUop[0];
  assign w_shamt  = iv_B[SHW-1:0];

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept && w_is_md) w_next_state = RUN;
      RUN:     if (r_cnt == LAST_RUN)   w_next_state = FIX;
      FIX:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Single-cycle ALU
  // ---------------------------------------------------------------------------
  always_comb begin
    w_alu = '0;
    case (iv_ALUop)
      OP_ADD:  w_alu = iv_A + iv_B;
      OP_SUB:  w_alu = iv_A - iv_B;
      OP_SLL:  w_alu = iv_A << w_shamt;
      OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, $signed(iv_A) < $signed(iv_B)};
      OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, iv_A < iv_B};
      OP_XOR:  w_alu = iv_A ^ iv_B;
      OP_SRL:  w_alu = iv_A >> w_shamt;
      OP_SRA:  w_alu = $signed(iv_A) >>> w_shamt;
      OP_OR:   w_alu = iv_A | iv_B;
      OP_AND:  w_alu = iv_A & iv_B;
      OP_BGE:  w_alu = {{(XLEN-1){1'b0}}, $signed(iv_A) >= $signed(iv_B)};
      OP_BGEU: w_alu = {{(XLEN-1){1'b0}}, iv_A >= iv_B};
      OP_LUI:  w_alu = iv_B;
      default: w_alu = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Iterative multiply/divide datapath (works on operand magnitudes)
  // ---------------------------------------------------------------------------
  assign w_a_sgn = (iv_ALUop == OP_MULH) || (iv_ALUop == OP_MULHSU) ||
                   (iv_ALUop == OP_DIV)  || (iv_ALUop == OP_REM);
  assign w_b_sgn = (iv_ALUop == OP_MULH) || (iv_ALUop == OP_DIV) ||
                   (iv_ALUop == OP_REM);
  assign w_a_neg = w_a_sgn & iv_A[XLEN-1];
  assign w_b_neg = w_b_sgn & iv_B[XLEN-1];
  // The most-negative value maps onto itself, which read unsigned is the
  // correct magnitude 2^(XLEN-1).
  assign w_a_mag = w_a_neg ? -iv_A : iv_A;
  assign w_b_mag = w_b_neg ? -iv_B : iv_B;

  // Shift-add step: add the multiplicand when the current multiplier bit is
  // set, then shift {carry, hi, lo} right by one.
  assign w_msum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);

  // Restoring-division step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits. When it fits the
  // difference is below the divisor, so the low XLEN bits are exact.
  assign w_shift = {r_hi, r_lo[XLEN-1]};
  assign w_ge    = (w_shift >= {1'b0, r_opnd});

  always_comb begin
    w_step_hi = {w_msum[XLEN:1]};
    w_step_lo = {w_msum[0], r_lo[XLEN-1:1]};
    if (r_op[3]) begin
      w_step_hi = w_ge ? (w_shift[XLEN-1:0] - r_opnd) : w_shift[XLEN-1:0];
      w_step_lo = {r_lo[XLEN-2:0], w_ge};
    end
  end

  // Sign correction applied to the result of the final iteration.
  assign w_prod   = {w_step_hi, w_step_lo};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;
  assign w_quo    = r_neg_q ? -w_step_lo : w_step_lo;
  // With a zero divisor the remainder magnitude equals |dividend|, so the
  // dividend-sign correction already reproduces the dividend.
  assign w_rem    = r_neg_r ? -w_step_hi : w_step_hi;

  always_comb begin
    w_fix = '0;
    case (r_op)
      OP_MUL:                        w_fix = w_prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  w_fix = w_prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               w_fix = r_div0 ? '1 : w_quo;
      OP_REM, OP_REMU:               w_fix = w_rem;
      default:                       w_fix = '0;
    endcase
  end

  // NOTE: the datapath registers carry no reset; they are always loaded on
  // accept before being read, and the FSM alone decides when they matter.
  always_ff @(posedge i_clk) begin
    if (w_accept && w_is_md) begin
      r_op    <= iv_ALUop;
      r_hi    <= '0;
      r_lo    <= w_a_mag;
      r_opnd  <= w_b_mag;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      r_div0  <= (iv_B == '0);
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_hi  <= w_step_hi;
      r_lo  <= w_step_lo;
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b1;
    end else begin
      r_valid <= 1'b0;
      if (w_accept && !w_is_md) begin
        r_valid  <= 1'b1;
        r_result <= w_alu;
        r_zero   <= (w_alu == '0);
      end else if (r_state == FIX) begin
        r_valid  <= 1'b1;
        r_result <= w_fix;
        r_zero   <= (w_fix == '0);
      end
    end
  end

  assign o_ready     = w_ready;
  assign o_valid     = r_valid;
  assign ov_result   = r_result;
  assign o_zero_flag = r_zero;

endmodule
